// File: rtl/uart_send.sv
// uart_send: UART transmitter for the echo path. Each falling edge of rx_int latches one byte into a
// holding register, and the byte is sent as an 8N1 frame, LSB first. Define UART_TX_PARITY_EN to add an even-parity bit.
module uart_send #(
    parameter int BPS_CNT = 5208,
    parameter int BPS_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       rx_int,
    output logic       data_out,
    output logic       bps_start,
    output logic       tx_done,
    output logic       tx_overrun
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [BPS_W-1:0] BPS_LAST = BPS_W'(BPS_CNT - 1);

    state_t           state;
    state_t           state_nx;
    logic             rx_int_d;
    logic             trig;
    logic             load;
    logic             bit_end;
    logic             line_nx;
    logic [7:0]       hold;
    logic             hold_valid;
    logic [7:0]       shift;
    logic [BPS_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
`ifdef UART_TX_PARITY_EN
    logic             parity;
`endif

    assign trig      = rx_int_d & ~rx_int;
    assign load      = (state == IDLE) && hold_valid;
    assign bit_end   = (baud_cnt == BPS_LAST);
    assign bps_start = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_int_d <= 1'b0;
        else        rx_int_d <= rx_int;
    end

    // A trigger that coincides with the FSM draining hold is accepted, not dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold       <= 8'h00;
            hold_valid <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            tx_overrun <= trig && hold_valid && !load;
            if (trig && (!hold_valid || load)) begin
                hold       <= data_in;
                hold_valid <= 1'b1;
            end else if (load) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            data_out <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity   <= 1'b0;
`endif
        end else begin
            data_out <= line_nx;
            if (state == IDLE || bit_end) baud_cnt <= '0;
            else                          baud_cnt <= baud_cnt + 1'b1;
            if (load) begin
                shift   <= hold;
                bit_cnt <= 3'd0;
`ifdef UART_TX_PARITY_EN
                parity  <= ^hold;
`endif
            end else if (state == DATA && bit_end) begin
                shift   <= {1'b0, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // data_out is registered from the current state, so the line trails the state by one cycle.
    always_comb begin
        state_nx = state;
        line_nx  = 1'b1;
        tx_done  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) state_nx = START;
            end
            START: begin
                line_nx = 1'b0;
                if (bit_end) state_nx = DATA;
            end
            DATA: begin
                line_nx = shift[0];
                if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_nx = PARITY;
`else
                    state_nx = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_nx = parity;
                if (bit_end) state_nx = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tx_done  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: randomized check of uart_send. A frame-level reference model predicts
// data_out, bps_start, tx_done and tx_overrun for every cycle.
module tb_uart_send;
    localparam int BPS = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FR   = NB * BPS;
    localparam int MAXC = 8192;

    typedef struct {
        logic [7:0] b;
        int         t;
    } trg_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_int = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       data_out, bps_start, tx_done, tx_overrun;

    uart_send #(.BPS_CNT(BPS), .BPS_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .rx_int(rx_int),
        .data_out(data_out), .bps_start(bps_start), .tx_done(tx_done), .tx_overrun(tx_overrun)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    trg_t trq[$];
    logic log_line[MAXC], log_bs[MAXC], log_td[MAXC], log_ov[MAXC];
    logic exp_line[MAXC], exp_bs[MAXC], exp_td[MAXC], exp_ov[MAXC];

    // Index n holds the outputs as they stand just after rising edge n.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (cyc < MAXC) begin
            log_line[cyc] = data_out;
            log_bs[cyc]   = bps_start;
            log_td[cyc]   = tx_done;
            log_ov[cyc]   = tx_overrun;
        end
    end

    function automatic logic bit_of(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (idx == 9 && NB == 11) return ^b;
        return 1'b1;
    endfunction

    // Model: a byte in hold loads at the later of (trigger edge + 1) and (previous load + FR + 1).
    // A load at edge L puts the FSM in START after L and the line low after L+1.
    function automatic void build_exp(input int lo, input int hi);
        trg_t       fr[$];
        int         nf, pl, e;
        logic       pend;
        logic [7:0] pb;
        for (int i = lo; i <= hi; i++) begin
            exp_line[i] = 1'b1; exp_bs[i] = 1'b0; exp_td[i] = 1'b0; exp_ov[i] = 1'b0;
        end
        nf = 0; pl = 0; pend = 1'b0; pb = 8'h00;
        foreach (trq[i]) begin
            if (pend && trq[i].t > pl) begin
                fr.push_back('{pb, pl}); nf = pl + FR + 1; pend = 1'b0;
            end
            if (!pend) begin
                pb = trq[i].b; pl = (trq[i].t + 1 > nf) ? trq[i].t + 1 : nf; pend = 1'b1;
            end else if (trq[i].t == pl) begin
                fr.push_back('{pb, pl}); nf = pl + FR + 1; pb = trq[i].b; pl = nf;
            end else if (trq[i].t >= lo && trq[i].t <= hi) begin
                exp_ov[trq[i].t] = 1'b1;
            end
        end
        if (pend) fr.push_back('{pb, pl});
        foreach (fr[i]) begin
            for (int k = 0; k < FR; k++) begin
                e = fr[i].t + 1 + k;
                if (e >= lo && e <= hi) exp_line[e] = bit_of(fr[i].b, k / BPS);
                e = fr[i].t + k;
                if (e >= lo && e <= hi) exp_bs[e] = 1'b1;
            end
            e = fr[i].t + FR - 1;
            if (e >= lo && e <= hi) exp_td[e] = 1'b1;
        end
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Trigger is sampled at edge cyc+3 counted from entry; data_in is scrambled afterwards.
    task automatic trig_byte(input logic [7:0] b);
        @(posedge clk); #2;
        rx_int = 1'b1; data_in = b;
        @(posedge clk); #2;
        rx_int = 1'b0;
        trq.push_back('{b, cyc + 1});
        @(posedge clk); #2;
        data_in = 8'($urandom);
    endtask

    task automatic test_reset();
        int lo, hi;
        rst_n = 1'b0; rx_int = 1'b1; data_in = 8'hA5;
        repeat (3) @(posedge clk);
        #2;
        total += 4;
        if (data_out !== 1'b1)   begin bad++; $display("FAIL reset data_out got %b want 1", data_out); end
        if (bps_start !== 1'b0)  begin bad++; $display("FAIL reset bps_start got %b want 0", bps_start); end
        if (tx_done !== 1'b0)    begin bad++; $display("FAIL reset tx_done got %b want 0", tx_done); end
        if (tx_overrun !== 1'b0) begin bad++; $display("FAIL reset tx_overrun got %b want 0", tx_overrun); end
        rst_n = 1'b1;
        trq.delete();
        lo = cyc + 1;
        wait_cyc(20);
        hi = cyc;
        build_exp(lo, hi);
        for (int e = lo; e <= hi; e++) begin
            total += 4;
            if (log_line[e] !== exp_line[e]) begin bad++; $display("FAIL reset_idle data_out @%0d got %b want %b", e, log_line[e], exp_line[e]); end
            if (log_bs[e] !== exp_bs[e]) begin bad++; $display("FAIL reset_idle bps_start @%0d got %b want %b", e, log_bs[e], exp_bs[e]); end
            if (log_td[e] !== exp_td[e]) begin bad++; $display("FAIL reset_idle tx_done @%0d got %b want %b", e, log_td[e], exp_td[e]); end
            if (log_ov[e] !== exp_ov[e]) begin bad++; $display("FAIL reset_idle tx_overrun @%0d got %b want %b", e, log_ov[e], exp_ov[e]); end
        end
    endtask

    task automatic test_single();
        int lo, hi;
        trq.delete();
        lo = cyc + 1;
        trig_byte(8'hA5);
        wait_cyc(FR + 8);
        hi = cyc;
        build_exp(lo, hi);
        for (int e = lo; e <= hi; e++) begin
            total += 4;
            if (log_line[e] !== exp_line[e]) begin bad++; $display("FAIL single data_out @%0d got %b want %b", e, log_line[e], exp_line[e]); end
            if (log_bs[e] !== exp_bs[e]) begin bad++; $display("FAIL single bps_start @%0d got %b want %b", e, log_bs[e], exp_bs[e]); end
            if (log_td[e] !== exp_td[e]) begin bad++; $display("FAIL single tx_done @%0d got %b want %b", e, log_td[e], exp_td[e]); end
            if (log_ov[e] !== exp_ov[e]) begin bad++; $display("FAIL single tx_overrun @%0d got %b want %b", e, log_ov[e], exp_ov[e]); end
        end
    endtask

    task automatic test_back_to_back();
        int lo, hi;
        trq.delete();
        lo = cyc + 1;
        trig_byte(8'h3C);
        wait_cyc(3 * BPS);
        trig_byte(8'hC3);
        wait_cyc(2 * FR + 8);
        hi = cyc;
        build_exp(lo, hi);
        for (int e = lo; e <= hi; e++) begin
            total += 4;
            if (log_line[e] !== exp_line[e]) begin bad++; $display("FAIL b2b data_out @%0d got %b want %b", e, log_line[e], exp_line[e]); end
            if (log_bs[e] !== exp_bs[e]) begin bad++; $display("FAIL b2b bps_start @%0d got %b want %b", e, log_bs[e], exp_bs[e]); end
            if (log_td[e] !== exp_td[e]) begin bad++; $display("FAIL b2b tx_done @%0d got %b want %b", e, log_td[e], exp_td[e]); end
            if (log_ov[e] !== exp_ov[e]) begin bad++; $display("FAIL b2b tx_overrun @%0d got %b want %b", e, log_ov[e], exp_ov[e]); end
        end
    endtask

    // Third trigger lands on the exact edge the FSM drains hold for the second byte.
    task automatic test_same_cycle();
        int lo, hi, pl;
        trq.delete();
        lo = cyc + 1;
        trig_byte(8'h5A);
        wait_cyc(2 * BPS);
        trig_byte(8'h96);
        pl = trq[0].t + FR + 2;
        wait_cyc(pl - cyc - 3);
        trig_byte(8'hE1);
        wait_cyc(3 * FR + 8);
        hi = cyc;
        build_exp(lo, hi);
        for (int e = lo; e <= hi; e++) begin
            total += 4;
            if (log_line[e] !== exp_line[e]) begin bad++; $display("FAIL same_cycle data_out @%0d got %b want %b", e, log_line[e], exp_line[e]); end
            if (log_bs[e] !== exp_bs[e]) begin bad++; $display("FAIL same_cycle bps_start @%0d got %b want %b", e, log_bs[e], exp_bs[e]); end
            if (log_td[e] !== exp_td[e]) begin bad++; $display("FAIL same_cycle tx_done @%0d got %b want %b", e, log_td[e], exp_td[e]); end
            if (log_ov[e] !== exp_ov[e]) begin bad++; $display("FAIL same_cycle tx_overrun @%0d got %b want %b", e, log_ov[e], exp_ov[e]); end
        end
    endtask

    task automatic test_overrun();
        int lo, hi;
        trq.delete();
        lo = cyc + 1;
        trig_byte(8'h01);
        wait_cyc(15);
        trig_byte(8'h02);
        wait_cyc(8);
        trig_byte(8'h03);
        wait_cyc(2 * FR + 8);
        hi = cyc;
        build_exp(lo, hi);
        for (int e = lo; e <= hi; e++) begin
            total += 4;
            if (log_line[e] !== exp_line[e]) begin bad++; $display("FAIL overrun data_out @%0d got %b want %b", e, log_line[e], exp_line[e]); end
            if (log_bs[e] !== exp_bs[e]) begin bad++; $display("FAIL overrun bps_start @%0d got %b want %b", e, log_bs[e], exp_bs[e]); end
            if (log_td[e] !== exp_td[e]) begin bad++; $display("FAIL overrun tx_done @%0d got %b want %b", e, log_td[e], exp_td[e]); end
            if (log_ov[e] !== exp_ov[e]) begin bad++; $display("FAIL overrun tx_overrun @%0d got %b want %b", e, log_ov[e], exp_ov[e]); end
        end
    endtask

    task automatic test_reset_abort();
        int lo, hi;
        trq.delete();
        lo = cyc + 1;
        trig_byte(8'hFF);
        wait_cyc(18);
        hi = cyc;
        build_exp(lo, hi);
        for (int e = lo; e <= hi; e++) begin
            total += 2;
            if (log_line[e] !== exp_line[e]) begin bad++; $display("FAIL abort_pre data_out @%0d got %b want %b", e, log_line[e], exp_line[e]); end
            if (log_bs[e] !== exp_bs[e]) begin bad++; $display("FAIL abort_pre bps_start @%0d got %b want %b", e, log_bs[e], exp_bs[e]); end
        end
        rst_n = 1'b0;
        #1;
        total += 3;
        if (data_out !== 1'b1)  begin bad++; $display("FAIL abort data_out got %b want 1", data_out); end
        if (bps_start !== 1'b0) begin bad++; $display("FAIL abort bps_start got %b want 0", bps_start); end
        if (tx_done !== 1'b0)   begin bad++; $display("FAIL abort tx_done got %b want 0", tx_done); end
        @(posedge clk); #2;
        rst_n = 1'b1;
        trq.delete();
        lo = cyc + 1;
        trig_byte(8'h55);
        wait_cyc(FR + 8);
        hi = cyc;
        build_exp(lo, hi);
        for (int e = lo; e <= hi; e++) begin
            total += 4;
            if (log_line[e] !== exp_line[e]) begin bad++; $display("FAIL abort_post data_out @%0d got %b want %b", e, log_line[e], exp_line[e]); end
            if (log_bs[e] !== exp_bs[e]) begin bad++; $display("FAIL abort_post bps_start @%0d got %b want %b", e, log_bs[e], exp_bs[e]); end
            if (log_td[e] !== exp_td[e]) begin bad++; $display("FAIL abort_post tx_done @%0d got %b want %b", e, log_td[e], exp_td[e]); end
            if (log_ov[e] !== exp_ov[e]) begin bad++; $display("FAIL abort_post tx_overrun @%0d got %b want %b", e, log_ov[e], exp_ov[e]); end
        end
    endtask

    task automatic test_random();
        int lo, hi;
        trq.delete();
        lo = cyc + 1;
        for (int n = 0; n < 12; n++) begin
            trig_byte(8'($urandom));
            wait_cyc($urandom_range(0, FR + 10));
        end
        wait_cyc(3 * FR);
        hi = cyc;
        build_exp(lo, hi);
        for (int e = lo; e <= hi; e++) begin
            total += 4;
            if (log_line[e] !== exp_line[e]) begin bad++; $display("FAIL random data_out @%0d got %b want %b", e, log_line[e], exp_line[e]); end
            if (log_bs[e] !== exp_bs[e]) begin bad++; $display("FAIL random bps_start @%0d got %b want %b", e, log_bs[e], exp_bs[e]); end
            if (log_td[e] !== exp_td[e]) begin bad++; $display("FAIL random tx_done @%0d got %b want %b", e, log_td[e], exp_td[e]); end
            if (log_ov[e] !== exp_ov[e]) begin bad++; $display("FAIL random tx_overrun @%0d got %b want %b", e, log_ov[e], exp_ov[e]); end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int lo, hi;
        trq.delete();
        lo = cyc + 1;
        trig_byte(8'h07);
        wait_cyc(FR + 4);
        trig_byte(8'h03);
        wait_cyc(FR + 8);
        hi = cyc;
        build_exp(lo, hi);
        for (int e = lo; e <= hi; e++) begin
            total += 4;
            if (log_line[e] !== exp_line[e]) begin bad++; $display("FAIL parity data_out @%0d got %b want %b", e, log_line[e], exp_line[e]); end
            if (log_bs[e] !== exp_bs[e]) begin bad++; $display("FAIL parity bps_start @%0d got %b want %b", e, log_bs[e], exp_bs[e]); end
            if (log_td[e] !== exp_td[e]) begin bad++; $display("FAIL parity tx_done @%0d got %b want %b", e, log_td[e], exp_td[e]); end
            if (log_ov[e] !== exp_ov[e]) begin bad++; $display("FAIL parity tx_overrun @%0d got %b want %b", e, log_ov[e], exp_ov[e]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_same_cycle();
        test_overrun();
        test_reset_abort();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
